// File: rtl/kth_ss_accel.sv
// kth_ss_accel: APB-attached compute subsystem.
//   The host loads a 64-word instruction memory and a 24-word input buffer,
//   writes CALL, polls STATUS.RET, then reads the 16-word output buffer.
//   The engine executes one instruction per cycle.
//
// Ports:
//   clk_in, reset_int        system clock, asynchronous active-low reset
//   PADDR/PSEL/PENABLE/
//   PWRITE/PWDATA            APB request (zero wait states)
//   PRDATA/PREADY/PSLVERR    APB response (PRDATA combinational)
//   irq_3, irq_en_3          completion interrupt and its enable
//   ss_ctrl_3                subsystem control byte
//   pmod_gpo, pmod_gpio_oe   status mirror and GPIO output enable
//   high_speed_clk, pmod_gpi unused
//
// Engine states:
//   state  | meaning
//   S_IDLE | waiting for CALL; call_pend marks an accepted CALL for one cycle
//   S_RUN  | executing imem[pc] every cycle until HALT or after pc = 63
module kth_ss_accel #(
  parameter logic [31:0] INSTR_BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] INSTR_SIZE_BYTES   = 32'd256,
  parameter logic [31:0] DATA_IN_BASE_ADDR  = 32'h0000_1000,
  parameter logic [31:0] DATA_IN_SIZE_BYTES = 32'd96,
  parameter logic [31:0] DATA_OUT_BASE_ADDR = 32'h0000_2000,
  parameter logic [31:0] DATA_OUT_SIZE_BYTES = 32'd64,
  parameter logic [31:0] CTRL_BASE_ADDR     = 32'h0000_3000,
  parameter logic [31:0] CTRL_SIZE_BYTES    = 32'd12
) (
  input  logic        clk_in,
  input  logic        reset_int,
  input  logic [31:0] PADDR,
  input  logic        PENABLE,
  input  logic        PSEL,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        high_speed_clk,
  output logic        irq_3,
  input  logic        irq_en_3,
  input  logic [7:0]  ss_ctrl_3,
  input  logic [15:0] pmod_gpi,
  output logic [15:0] pmod_gpo,
  output logic [15:0] pmod_gpio_oe
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [31:0] imem [64];
  logic [31:0] din  [24];
  logic [31:0] dout [16];
  logic [31:0] cell_sel;
  logic        ret;
  logic        busy;
  logic        call_pend;
  logic        irq_q;
  logic [5:0]  pc;
  state_t      state;

  // Address decode: an offset below the region size is a hit; an address
  // below the base wraps to a large offset and misses.
  logic [31:0] off_imem, off_din, off_dout, off_ctrl;
  logic        hit_imem, hit_din, hit_dout, hit_ctrl, mapped;
  logic [5:0]  idx_imem;
  logic [4:0]  idx_din;
  logic [3:0]  idx_dout;
  logic [1:0]  idx_ctrl;

  assign off_imem = PADDR - INSTR_BASE_ADDR;
  assign off_din  = PADDR - DATA_IN_BASE_ADDR;
  assign off_dout = PADDR - DATA_OUT_BASE_ADDR;
  assign off_ctrl = PADDR - CTRL_BASE_ADDR;

  assign hit_imem = off_imem < INSTR_SIZE_BYTES;
  assign hit_din  = off_din  < DATA_IN_SIZE_BYTES;
  assign hit_dout = off_dout < DATA_OUT_SIZE_BYTES;
  assign hit_ctrl = off_ctrl < CTRL_SIZE_BYTES;
  assign mapped   = hit_imem | hit_din | hit_dout | hit_ctrl;

  assign idx_imem = off_imem[7:2];
  assign idx_din  = off_din[6:2];
  assign idx_dout = off_dout[5:2];
  assign idx_ctrl = off_ctrl[3:2];

  logic err, wr_ok, call_req;

  assign err = PSEL & PENABLE &
               (~mapped | (PWRITE & hit_dout) |
                (PWRITE & busy & (hit_imem | hit_din)));
  assign wr_ok    = PSEL & PENABLE & PWRITE & ~err;
  assign call_req = wr_ok & hit_ctrl & (idx_ctrl == 2'd1) & PWDATA[0];

  assign PSLVERR = err;
  assign PREADY  = 1'b1;

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      if (hit_imem)      PRDATA = imem[idx_imem];
      else if (hit_din)  PRDATA = din[idx_din];
      else if (hit_dout) PRDATA = dout[idx_dout];
      else if (hit_ctrl) begin
        case (idx_ctrl)
          2'd0:    PRDATA = cell_sel;
          2'd2:    PRDATA = {30'b0, busy, ret};
          default: PRDATA = '0;
        endcase
      end
    end
  end

  // Instruction decode of the word at pc.
  logic [31:0] instr;
  logic [3:0]  op, dst;
  logic [4:0]  fa, fb;
  logic [31:0] opa, opb, sa, sb, mul_res;

  assign instr = imem[pc];
  assign op    = instr[31:28];
  assign dst   = instr[27:24];
  assign fa    = instr[22:18];
  assign fb    = instr[17:13];
  assign opa   = (fa < 5'd24) ? din[fa] : 32'h0;
  assign opb   = (fb < 5'd24) ? din[fb] : 32'h0;

  // Sign-extended 16-bit operands; the low 32 bits of the product are exact.
  assign sa      = {{16{opa[15]}}, opa[15:0]};
  assign sb      = {{16{opb[15]}}, opb[15:0]};
  assign mul_res = sa * sb;

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      for (int i = 0; i < 64; i++) imem[i] <= '0;
      for (int i = 0; i < 24; i++) din[i]  <= '0;
      for (int i = 0; i < 16; i++) dout[i] <= '0;
      cell_sel  <= '0;
      ret       <= 1'b0;
      busy      <= 1'b0;
      call_pend <= 1'b0;
      irq_q     <= 1'b0;
      pc        <= '0;
      state     <= S_IDLE;
    end else begin
      irq_q <= ret & irq_en_3;

      if (wr_ok) begin
        if (hit_imem) imem[idx_imem] <= PWDATA;
        if (hit_din)  din[idx_din]   <= PWDATA;
        if (hit_ctrl && idx_ctrl == 2'd0) cell_sel <= PWDATA;
      end

      case (state)
        S_IDLE: begin
          if (call_pend) begin
            call_pend <= 1'b0;
            ret       <= 1'b0;
            pc        <= '0;
            busy      <= 1'b1;
            state     <= S_RUN;
          end else if (call_req) begin
            call_pend <= 1'b1;
          end
        end
        S_RUN: begin
          if (op == 4'd0) begin
            busy  <= 1'b0;
            ret   <= 1'b1;
            state <= S_IDLE;
          end else begin
            case (op)
              4'd1:    dout[dst] <= opa + opb;
              4'd2:    dout[dst] <= opa - opb;
              4'd3:    dout[dst] <= mul_res;
              4'd4:    dout[dst] <= opa;
              default: ;
            endcase
            pc <= pc + 6'd1;
            if (pc == 6'd63) begin
              busy  <= 1'b0;
              ret   <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign irq_3        = irq_q;
  assign pmod_gpo     = {ss_ctrl_3, pc, ret, busy};
  assign pmod_gpio_oe = ss_ctrl_3[0] ? 16'hFFFF : 16'h0000;

  logic unused_sig;
  assign unused_sig = ^{high_speed_clk, pmod_gpi, instr[23], instr[12:0],
                        sa[31:16], sb[31:16]};

endmodule

// File: tb/tb_kth_ss_accel.sv
module tb_kth_ss_accel;

  localparam logic [31:0] A_IMEM = 32'h0000_0000;
  localparam logic [31:0] A_DIN  = 32'h0000_1000;
  localparam logic [31:0] A_DOUT = 32'h0000_2000;
  localparam logic [31:0] A_CELL = 32'h0000_3000;
  localparam logic [31:0] A_CALL = 32'h0000_3004;
  localparam logic [31:0] A_STAT = 32'h0000_3008;

  logic        clk_in = 1'b0;
  logic        reset_int = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PENABLE = 1'b0;
  logic        PSEL = 1'b0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        high_speed_clk = 1'b0;
  logic        irq_3;
  logic        irq_en_3 = 1'b0;
  logic [7:0]  ss_ctrl_3 = 8'h00;
  logic [15:0] pmod_gpi = '0;
  logic [15:0] pmod_gpo;
  logic [15:0] pmod_gpio_oe;

  kth_ss_accel dut (
    .clk_in(clk_in), .reset_int(reset_int), .PADDR(PADDR), .PENABLE(PENABLE),
    .PSEL(PSEL), .PWDATA(PWDATA), .PWRITE(PWRITE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .high_speed_clk(high_speed_clk),
    .irq_3(irq_3), .irq_en_3(irq_en_3), .ss_ctrl_3(ss_ctrl_3),
    .pmod_gpi(pmod_gpi), .pmod_gpo(pmod_gpo), .pmod_gpio_oe(pmod_gpio_oe)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [31:0] m_imem [64];
  logic [31:0] m_din  [24];
  logic [31:0] m_dout [16];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          wr;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the commit edge.
  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    #1 e = PSLVERR;
    @(posedge clk_in); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
    #1 d = PRDATA; e = PSLVERR;
    @(posedge clk_in); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr_ok(input string nm, input logic [31:0] a, input logic [31:0] d);
    logic e;
    apb_wr(a, d, e);
    chk(nm, {31'b0, e}, 32'h0);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 64; i++) wr_ok("imem_load_err", A_IMEM + 32'(4 * i), m_imem[i]);
  endtask

  task automatic load_din();
    for (int i = 0; i < 24; i++) wr_ok("din_load_err", A_DIN + 32'(4 * i), m_din[i]);
  endtask

  task automatic check_dout(input string nm);
    logic [31:0] d;
    logic e;
    for (int i = 0; i < 16; i++) begin
      apb_rd(A_DOUT + 32'(4 * i), d, e);
      chk(nm, d, m_dout[i]);
    end
  endtask

  // Reference: interpret the program; returns the cycle count from the
  // CALL edge to RET (instructions executed, HALT included, plus one).
  function automatic int model_exec();
    int n = 64;
    for (int p = 0; p < 64; p++) begin
      logic [31:0] w, va, vb;
      logic [3:0]  op;
      logic [4:0]  a, b;
      logic signed [15:0] ha, hb;
      w  = m_imem[p];
      op = w[31:28];
      if (op == 4'd0) begin
        n = p + 1;
        break;
      end
      a  = w[22:18];
      b  = w[17:13];
      va = (int'(a) < 24) ? m_din[a] : 32'h0;
      vb = (int'(b) < 24) ? m_din[b] : 32'h0;
      ha = va[15:0];
      hb = vb[15:0];
      case (op)
        4'd1: m_dout[w[27:24]] = va + vb;
        4'd2: m_dout[w[27:24]] = va - vb;
        4'd3: m_dout[w[27:24]] = 32'(int'(ha) * int'(hb));
        4'd4: m_dout[w[27:24]] = va;
        default: ;
      endcase
    end
    return n + 1;
  endfunction

  int c0;

  task automatic start_call();
    wr_ok("call_err", A_CALL, 32'h1);
    c0 = cyc;
  endtask

  task automatic wait_ret(input string nm, input int exp_cyc);
    @(posedge clk_in); #1;
    while (!pmod_gpo[1] && (cyc - c0) < 300) begin
      @(posedge clk_in); #1;
    end
    chk(nm, 32'(cyc - c0), 32'(exp_cyc));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) m_imem[i] = '0;
    for (int i = 0; i < 24; i++) m_din[i] = '0;
    for (int i = 0; i < 16; i++) m_dout[i] = '0;
  endtask

  initial begin
    logic [31:0] d;
    logic e;
    int ec;

    vecs[0]  = '{32'h0000_0000, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'hA5A5_0001};
    vecs[2]  = '{32'h0000_00FC, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{32'h0000_00FC, 32'h0,         1'b0, 1'b0, 32'h1234_5678};
    vecs[4]  = '{32'h0000_0100, 32'h1111_1111, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{32'h0000_0100, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[6]  = '{32'h0000_105C, 32'h0000_0077, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{32'h0000_105C, 32'h0,         1'b0, 1'b0, 32'h0000_0077};
    vecs[8]  = '{32'h0000_1060, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[9]  = '{32'h0000_2000, 32'h0000_0001, 1'b1, 1'b1, 32'h0};
    vecs[10] = '{32'h0000_2000, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[11] = '{32'h0000_2040, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[12] = '{32'h0000_3000, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{32'h0000_3000, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[14] = '{32'h0000_3004, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[15] = '{32'h0000_3008, 32'h0000_0003, 1'b1, 1'b0, 32'h0};
    vecs[16] = '{32'h0000_3008, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[17] = '{32'h0000_300C, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[18] = '{32'h0000_0FFC, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[19] = '{32'h0000_203C, 32'h0,         1'b0, 1'b0, 32'h0};

    clear_model();

    // Reset state
    #12;
    chk("rst_gpo", {16'h0, pmod_gpo}, 32'h0);
    chk("rst_oe", {16'h0, pmod_gpio_oe}, 32'h0);
    chk("rst_irq", {31'b0, irq_3}, 32'h0);
    chk("rst_pready", {31'b0, PREADY}, 32'h1);
    chk("rst_prdata", PRDATA, 32'h0);
    reset_int = 1'b1;
    @(posedge clk_in); #1;

    // Decode / access-rights table
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        apb_wr(vecs[i].addr, vecs[i].wdata, e);
        chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].err});
      end else begin
        apb_rd(vecs[i].addr, d, e);
        chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].err});
        chk($sformatf("vec%0d_rd", i), d, vecs[i].rdata);
      end
    end
    m_din[23] = 32'h77;

    // ADD program
    for (int i = 0; i < 64; i++) m_imem[i] = '0;
    m_imem[0] = 32'h1000_2000;
    m_din[0] = 32'd5;
    m_din[1] = 32'd7;
    load_prog();
    wr_ok("din0", A_DIN, m_din[0]);
    wr_ok("din1", A_DIN + 4, m_din[1]);
    ec = model_exec();
    start_call();
    wait_ret("add_cycles", 3);
    chk("add_model_cycles", 32'(ec), 32'd3);
    apb_rd(A_STAT, d, e);
    chk("add_status", d, 32'h1);
    apb_rd(A_DOUT, d, e);
    chk("add_out0", d, 32'd12);
    check_dout("add_dout");

    // MUL program
    m_imem[0] = 32'h3508_6000;
    m_imem[1] = 32'h0;
    m_din[2] = 32'h0000_FFFE;
    m_din[3] = 32'd3;
    load_prog();
    wr_ok("din2", A_DIN + 8, m_din[2]);
    wr_ok("din3", A_DIN + 12, m_din[3]);
    ec = model_exec();
    start_call();
    wait_ret("mul_cycles", ec);
    apb_rd(A_DOUT + 20, d, e);
    chk("mul_out5", d, 32'hFFFF_FFFA);
    check_dout("mul_dout");

    // Back-to-back input writes and readback
    for (int i = 0; i < 24; i++) m_din[i] = $urandom;
    load_din();
    for (int i = 0; i < 24; i++) begin
      apb_rd(A_DIN + 32'(4 * i), d, e);
      chk("din_readback", d, m_din[i]);
    end
    apb_rd(A_DIN + 32'h60, d, e);
    chk("din_oob_err", {31'b0, e}, 32'h1);

    // Random programs against the reference interpreter
    for (int r = 0; r < 6; r++) begin
      int halt_at;
      halt_at = $urandom_range(0, 80);
      for (int p = 0; p < 64; p++) begin
        logic [31:0] w;
        w = $urandom;
        w[31:28] = 4'($urandom_range(1, 7));
        m_imem[p] = (p == halt_at) ? 32'h0 : w;
      end
      for (int i = 0; i < 24; i++) m_din[i] = $urandom;
      load_prog();
      load_din();
      ec = model_exec();
      start_call();
      wait_ret("rand_cycles", ec);
      check_dout("rand_dout");
    end

    // All-NOP program: full 64 instructions, CALL and writes during run
    for (int i = 0; i < 64; i++) m_imem[i] = 32'h5000_0000;
    load_prog();
    ec = model_exec();
    chk("nop_model_cycles", 32'(ec), 32'd65);
    start_call();
    @(posedge clk_in); #1;
    chk("nop_busy", {30'b0, pmod_gpo[1:0]}, 32'h1);
    wr_ok("call_mid_run", A_CALL, 32'h1);
    apb_wr(A_IMEM + 32'h10, 32'hDEAD_0000, e);
    chk("imem_busy_err", {31'b0, e}, 32'h1);
    apb_wr(A_DIN, 32'hDEAD_0001, e);
    chk("din_busy_err", {31'b0, e}, 32'h1);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    while (!pmod_gpo[1] && (cyc - c0) < 300) begin
      @(posedge clk_in); #1;
    end
    chk("nop_cycles", 32'(cyc - c0), 32'd65);
    repeat (4) @(posedge clk_in);
    #1 chk("nop_no_rerun", {30'b0, pmod_gpo[1:0]}, 32'h2);
    apb_rd(A_IMEM + 32'h10, d, e);
    chk("imem_unchanged", d, 32'h5000_0000);
    apb_rd(A_DIN, d, e);
    chk("din_unchanged", d, m_din[0]);
    check_dout("nop_dout");

    // Interrupt
    apb_wr(A_DOUT + 4, 32'h1234, e);
    chk("dout_wr_err", {31'b0, e}, 32'h1);
    apb_rd(A_DOUT + 4, d, e);
    chk("dout_wr_noeffect", d, m_dout[1]);
    chk("irq_disabled", {31'b0, irq_3}, 32'h0);
    irq_en_3 = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    chk("irq_set", {31'b0, irq_3}, 32'h1);
    start_call();
    @(posedge clk_in); #1;
    chk("call_clears_ret", {31'b0, pmod_gpo[1]}, 32'h0);
    @(posedge clk_in); #1;
    chk("call_clears_irq", {31'b0, irq_3}, 32'h0);

    // Reset during RUN
    repeat (5) @(posedge clk_in);
    #1 chk("pre_reset_busy", {31'b0, pmod_gpo[0]}, 32'h1);
    ss_ctrl_3 = 8'hA5;
    #1 reset_int = 1'b0;
    #1;
    chk("rst_run_gpo", {16'h0, pmod_gpo}, 32'h0000_A500);
    chk("rst_run_irq", {31'b0, irq_3}, 32'h0);
    chk("rst_run_oe", {16'h0, pmod_gpio_oe}, 32'h0000_FFFF);
    @(posedge clk_in); #3;
    reset_int = 1'b1;
    @(posedge clk_in); #1;
    clear_model();
    apb_rd(A_STAT, d, e);
    chk("rst_run_status", d, 32'h0);
    apb_rd(A_CELL, d, e);
    chk("rst_run_cell", d, 32'h0);
    apb_rd(A_IMEM, d, e);
    chk("rst_run_imem", d, 32'h0);
    check_dout("rst_run_dout");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
